// File: rtl/ctr_gen_pkg.sv
// Shared types and helpers for the counter block generator.
// Holds the control-state encoding and the lane-mask builder.
package ctr_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MAX_LANES = 64;

    // Low min(n, lanes) bits set; callers keep only their LANES low bits.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned n,
                                                      input int unsigned lanes);
        int unsigned k;
        logic [MAX_LANES-1:0] m;
        k = (n < lanes) ? n : lanes;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < k) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ctr_block_gen.sv
// Registered counter block generator: emits LANES consecutive counter values per
// accepted beat, with lane masking, end-of-message marking and sticky wrap detection.
module ctr_block_gen
    import ctr_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1,
    parameter int LEN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       key,
    input  logic                   start,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic                   ctr_ready,
    output logic                   ctr_valid,
    output logic [LANES*WIDTH-1:0] ctr_data,
    output logic [LANES-1:0]       ctr_lane_valid,
    output logic                   ctr_last,
    output logic                   wrap_err
);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_base;
    logic [LEN_W-1:0]       r_rem;
    logic [LANES*WIDTH-1:0] r_data;
    logic [LANES-1:0]       r_mask;
    logic                   r_last;
    logic                   r_wrap;

    logic                   w_xfer;
    logic [LEN_W-1:0]       w_cur_n;
    logic [LEN_W-1:0]       w_rem_after;
    logic [WIDTH-1:0]       w_next_base;
    logic                   w_step_carry;
    logic [WIDTH-1:0]       w_src_base;
    logic [LEN_W-1:0]       w_src_rem;
    logic [LEN_W-1:0]       w_src_n;
    logic [LEN_W-1:0]       w_src_n_m1;
    logic [WIDTH:0]         w_top;
    logic [LANES*WIDTH-1:0] w_src_data;
    logic [LANES-1:0]       w_src_mask;
    logic                   w_src_last;
    logic                   w_src_wrap;

    // A start in the same cycle pre-empts any handshake on the old beat.
    assign w_xfer      = (r_state == RUN) && ctr_ready && !start;
    assign w_cur_n     = (r_rem > LEN_W'(LANES)) ? LEN_W'(LANES) : r_rem;
    assign w_rem_after = r_rem - w_cur_n;
    assign {w_step_carry, w_next_base} = {1'b0, r_base} + (WIDTH+1)'(LANES);

    // Candidate beat: either the first beat of a new message or the successor beat.
    assign w_src_base = start ? key : w_next_base;
    assign w_src_rem  = start ? msg_len : w_rem_after;
    assign w_src_n    = (w_src_rem > LEN_W'(LANES)) ? LEN_W'(LANES) : w_src_rem;
    assign w_src_n_m1 = (w_src_n == '0) ? '0 : w_src_n - 1'b1;
    assign w_top      = {1'b0, w_src_base} + (WIDTH+1)'(w_src_n_m1);
    assign w_src_mask = LANES'(lane_mask(32'(w_src_n), LANES));
    assign w_src_last = (w_src_rem <= LEN_W'(LANES));
    assign w_src_wrap = w_top[WIDTH] | (!start & w_step_carry);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_src_data[g*WIDTH +: WIDTH] = w_src_base + WIDTH'(g);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset branch clears every register, outputs included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_last  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (start) begin
            if (msg_len != '0) begin
                r_state <= RUN;
                r_base  <= key;
                r_rem   <= msg_len;
                r_data  <= w_src_data;
                r_mask  <= w_src_mask;
                r_last  <= w_src_last;
                r_wrap  <= w_src_wrap;
            end else begin
                r_state <= IDLE;
                r_wrap  <= 1'b0;
            end
        end else if (w_xfer) begin
            r_base <= w_next_base;
            r_rem  <= w_rem_after;
            if (r_last) begin
                r_state <= IDLE;
            end else begin
                r_data <= w_src_data;
                r_mask <= w_src_mask;
                r_last <= w_src_last;
                r_wrap <= r_wrap | w_src_wrap;
            end
        end
    end

    assign ctr_valid      = (r_state == RUN);
    assign ctr_data       = r_data;
    assign ctr_lane_valid = r_mask;
    assign ctr_last       = r_last;
    assign wrap_err       = r_wrap;

endmodule
